// File: rtl/tc_sram_bank_pwr_ctrl.sv
// Per-bank power sequencer for a multibank SRAM. It wakes banks on demand,
// stalls the requester until the bank is usable, auto-sleeps idle banks and enforces power-gating.
module tc_sram_bank_pwr_ctrl #(
    parameter int NumWords      = 1024,
    parameter int NumLogicBanks = 4,
    parameter int WakeCycles    = 2,
    parameter int IdleCycles    = 16,
    parameter int AddrWidth     = $clog2(NumWords)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    input  logic [AddrWidth-1:0]     req_addr_i,
    output logic                     req_ready_o,
    output logic                     req_err_o,
    output logic                     sram_req_o,
    input  logic [NumLogicBanks-1:0] cfg_powergate_i,
    output logic [NumLogicBanks-1:0] deepsleep_o,
    output logic [NumLogicBanks-1:0] powergate_o,
    output logic [NumLogicBanks-1:0] bank_on_o
);
    localparam int BankBits = $clog2(NumLogicBanks);
    localparam int MaxCount = (WakeCycles > IdleCycles) ? WakeCycles : IdleCycles;
    localparam int CntWidth = $clog2(MaxCount + 1);
    localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeCycles - 1);
    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);

    typedef enum logic [1:0] {
        StSleep,
        StWake,
        StOn,
        StOff
    } state_e;

    state_e              state_q [NumLogicBanks];
    state_e              state_d [NumLogicBanks];
    logic [CntWidth-1:0] cnt_q   [NumLogicBanks];
    logic [CntWidth-1:0] cnt_d   [NumLogicBanks];

    logic [BankBits-1:0] bank_sel;
    logic                unused_addr_bits;

    // Only the top address bits select a bank; the word offset passes straight to the SRAM.
    assign bank_sel         = req_addr_i[AddrWidth-1 -: BankBits];
    assign unused_addr_bits = ^req_addr_i[AddrWidth-BankBits-1:0];

    always_comb begin
        req_ready_o = req_valid_i && ((state_q[bank_sel] == StOn) || (state_q[bank_sel] == StOff));
        req_err_o   = req_valid_i && (state_q[bank_sel] == StOff);
        sram_req_o  = req_ready_o && !req_err_o;
    end

    // One counter per bank serves as wake timer in WAKE and idle timer in ON.
    always_comb begin
        logic hit;
        for (int b = 0; b < NumLogicBanks; b++) begin
            hit        = req_valid_i && (bank_sel == BankBits'(b));
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            if (cfg_powergate_i[b] && (state_q[b] != StOff)) begin
                state_d[b] = StOff;
                cnt_d[b]   = '0;
            end else begin
                case (state_q[b])
                    StOff: begin
                        if (!cfg_powergate_i[b]) begin
                            state_d[b] = StSleep;
                            cnt_d[b]   = '0;
                        end
                    end
                    StSleep: begin
                        if (hit) begin
                            state_d[b] = StWake;
                            cnt_d[b]   = '0;
                        end
                    end
                    StWake: begin
                        if (cnt_q[b] == WakeLast) begin
                            state_d[b] = StOn;
                            cnt_d[b]   = '0;
                        end else begin
                            cnt_d[b] = cnt_q[b] + CntWidth'(1);
                        end
                    end
                    StOn: begin
                        if (hit) begin
                            cnt_d[b] = '0;
                        end else if (IdleCycles != 0) begin
                            if (cnt_q[b] == IdleLast) begin
                                state_d[b] = StSleep;
                                cnt_d[b]   = '0;
                            end else begin
                                cnt_d[b] = cnt_q[b] + CntWidth'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[b] = StSleep;
                        cnt_d[b]   = '0;
                    end
                endcase
            end
        end
    end

    // Bank control outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NumLogicBanks; b++) begin
                state_q[b] <= StSleep;
                cnt_q[b]   <= '0;
            end
            deepsleep_o <= '1;
            powergate_o <= '0;
            bank_on_o   <= '0;
        end else begin
            for (int b = 0; b < NumLogicBanks; b++) begin
                state_q[b]     <= state_d[b];
                cnt_q[b]       <= cnt_d[b];
                deepsleep_o[b] <= (state_d[b] == StSleep) || (state_d[b] == StOff);
                powergate_o[b] <= (state_d[b] == StOff);
                bank_on_o[b]   <= (state_d[b] == StOn);
            end
        end
    end

endmodule

// File: tb/tb_tc_sram_bank_pwr_ctrl.sv
// Bench for tc_sram_bank_pwr_ctrl: two instances (auto-sleep after 16 idle cycles, and auto-sleep disabled)
// share one requester and are compared every cycle against a timestamp-based model of bank power.
module tb_tc_sram_bank_pwr_ctrl;
    localparam int W  = 2;
    localparam int I  = 16;
    localparam int NB = 4;
    localparam int AW = 10;
    localparam int BB = 2;

    localparam int MSleep = 0;
    localparam int MWake  = 1;
    localparam int MOn    = 2;
    localparam int MOff   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [AW-1:0] addr;
    logic [NB-1:0] cfg;

    logic          readyA, errA, sramA;
    logic [NB-1:0] dsA, pgA, onA;
    logic          readyB, errB, sramB;
    logic [NB-1:0] dsB, pgB, onB;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    bit mOff     [2][NB];
    int mAwake   [2][NB];
    int mSleepAt [2][NB];

    tc_sram_bank_pwr_ctrl #(.NumWords(1024), .NumLogicBanks(NB), .WakeCycles(W), .IdleCycles(I)) dutA (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_addr_i(addr),
        .req_ready_o(readyA), .req_err_o(errA), .sram_req_o(sramA),
        .cfg_powergate_i(cfg), .deepsleep_o(dsA), .powergate_o(pgA), .bank_on_o(onA)
    );

    tc_sram_bank_pwr_ctrl #(.NumWords(1024), .NumLogicBanks(NB), .WakeCycles(W), .IdleCycles(0)) dutB (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_addr_i(addr),
        .req_ready_o(readyB), .req_err_o(errB), .sram_req_o(sramB),
        .cfg_powergate_i(cfg), .deepsleep_o(dsB), .powergate_o(pgB), .bank_on_o(onB)
    );

    always #5 clk = ~clk;

    function automatic int idleFor(int d);
        return (d == 0) ? I : 0;
    endfunction

    // A bank is ON from the cycle its wake finishes until its sleep deadline; no deadline when idle is 0.
    function automatic int mState(int d, int b);
        if (mOff[d][b]) return MOff;
        if (mAwake[d][b] < 0) return MSleep;
        if (cyc < mAwake[d][b]) return MWake;
        if (idleFor(d) == 0 || cyc < mSleepAt[d][b]) return MOn;
        return MSleep;
    endfunction

    function automatic logic [14:0] expVec(int d);
        logic [14:0] v;
        int          sel;
        int          st;
        logic        rdy, er;
        sel = int'(addr[AW-1 -: BB]);
        st  = mState(d, sel);
        rdy = valid && (st == MOn || st == MOff);
        er  = valid && (st == MOff);
        v   = '0;
        v[14] = rdy;
        v[13] = er;
        v[12] = rdy && !er;
        for (int b = 0; b < NB; b++) begin
            st       = mState(d, b);
            v[8 + b] = !(st == MWake || st == MOn);
            v[4 + b] = (st == MOff);
            v[b]     = (st == MOn);
        end
        return v;
    endfunction

    function automatic logic [14:0] obsVec(int d);
        if (d == 0) return {readyA, errA, sramA, dsA, pgA, onA};
        return {readyB, errB, sramB, dsB, pgB, onB};
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < NB; b++) begin
                mOff[d][b]     = 1'b0;
                mAwake[d][b]   = -1;
                mSleepAt[d][b] = 0;
            end
        end
    endtask

    task automatic modelAdvance();
        int  st;
        bit  hit;
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < NB; b++) begin
                st  = mState(d, b);
                hit = valid && (int'(addr[AW-1 -: BB]) == b);
                if (cfg[b] && st != MOff) begin
                    mOff[d][b]   = 1'b1;
                    mAwake[d][b] = -1;
                end else if (st == MOff) begin
                    if (!cfg[b]) mOff[d][b] = 1'b0;
                end else if (st == MSleep && hit) begin
                    mAwake[d][b]   = cyc + 1 + W;
                    mSleepAt[d][b] = mAwake[d][b] + idleFor(d);
                end else if (st == MOn && hit) begin
                    mSleepAt[d][b] = cyc + 1 + idleFor(d);
                end
            end
        end
        cyc++;
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [NB-1:0] c);
        valid = v;
        addr  = a;
        cfg   = c;
    endtask

    task automatic checkOutput(input string tag);
        logic [14:0] o, e;
        for (int d = 0; d < 2; d++) begin
            o = obsVec(d);
            e = expVec(d);
            checks++;
            assert (o === e) passes++;
            else $error("[TB] FAIL %s dut%0d observed=%b expected=%b (rdy,err,sram,ds,pg,on)", tag, d, o, e);
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelAdvance();
        #1;
    endtask

    // Counts cycles from now up to and including the cycle dutA signals ready.
    task automatic waitReady(input string tag, input int expCycles);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            checkOutput(tag);
            got = readyA;
            n++;
            @(posedge clk);
            modelAdvance();
            #1;
        end
        checks++;
        assert (got && n == expCycles) passes++;
        else $error("[TB] FAIL %s_latency observed=%0d required=%0d", tag, n, expCycles);
    endtask

    initial begin
        logic [14:0] ex;
        bit          held;
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0);
        modelReset();
        #1 rst = 1'b1;
        #1;
        checkOutput("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        $display("[TB] reset released");

        applyStimulus(1'b1, 10'h000, 4'b0000);
        waitReady("wake_b0", W + 2);
        applyStimulus(1'b0, 10'h000, 4'b0000);
        step("idle");

        applyStimulus(1'b1, 10'h100, 4'b0000);
        waitReady("wake_b1", W + 2);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 10'h100 + AW'(k), 4'b0000);
            step("b2b_b1");
        end
        applyStimulus(1'b0, 10'h100, 4'b0000);
        begin
            int n;
            n = 0;
            while (n < 40) begin
                @(negedge clk);
                checkOutput("autosleep_b1");
                n++;
                if (dsA[1]) break;
                @(posedge clk);
                modelAdvance();
                #1;
            end
            checks++;
            assert (dsA[1] === 1'b1 && n == I + 1) passes++;
            else $error("[TB] FAIL autosleep_delay observed=%0d required=%0d", n, I + 1);
            @(posedge clk);
            modelAdvance();
            #1;
        end

        applyStimulus(1'b0, 10'h200, 4'b0100);
        step("pg_rise");
        applyStimulus(1'b1, 10'h200, 4'b0100);
        step("pg_err_b2");
        step("pg_err_b2");
        applyStimulus(1'b0, 10'h200, 4'b0000);
        step("pg_release");
        applyStimulus(1'b1, 10'h200, 4'b0000);
        waitReady("wake_b2", W + 2);

        applyStimulus(1'b1, 10'h300, 4'b0000);
        step("b3_req");
        applyStimulus(1'b1, 10'h300, 4'b1000);
        step("b3_pg_in_wake");
        step("b3_err");
        applyStimulus(1'b0, 10'h300, 4'b0000);
        step("b3_release");

        applyStimulus(1'b1, 10'h000, 4'b0000);
        step("b0_req");
        step("b0_wake");
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        waitReady("rewake_b0", W + 2);

        applyStimulus(1'b1, 10'h2A5, 4'b0000);
        step("b2_access");
        applyStimulus(1'b0, 10'h000, 4'b0000);
        for (int k = 0; k < 30; k++) step("noidle_b2");
        checks++;
        assert (onB[2] === 1'b1 && dsB[2] === 1'b0) passes++;
        else $error("[TB] FAIL noidle_b2_on observed=%b%b required=10", onB[2], dsB[2]);

        held = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (held) begin
                if ($urandom_range(7) == 0) addr = AW'($urandom);
            end else begin
                valid = ($urandom_range(3) != 0);
                addr  = AW'($urandom);
            end
            if ($urandom_range(15) == 0) cfg[$urandom_range(NB - 1)] ^= 1'b1;
            ex   = expVec(0);
            held = valid && !ex[14];
            step("random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tc_sram_bank_pwr_ctrl.md
# tc_sram_bank_pwr_ctrl

Per-bank power sequencer for a multibank SRAM with per-bank `deepsleep_i`/`powergate_i` controls. The block sits between a single requester and the SRAM and drives those bank controls. It wakes a sleeping bank on demand and stalls the requester until the bank is usable. It returns banks to deep sleep after a programmable idle period and enforces software power-gating. Address, write data, write enable and byte enables bypass this block; only request gating and bank power controls pass through it.

## Interface
- `NumWords`, 1024: total SRAM words.
- `NumLogicBanks`, 4: logic banks; must be ≥2 and a power of two.
- `WakeCycles`, 2: cycles a bank spends in WAKE before it can be accessed; ≥1.
- `IdleCycles`, 16: consecutive non-granted ON cycles before auto-sleep; 0 disables auto-sleep.
- `AddrWidth`, `$clog2(NumWords)`: derived; do not override.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous reset, active-high.
- `req_valid_i` in 1: requester access request.
- `req_addr_i` in AddrWidth: word address. Bank = `req_addr_i[AddrWidth-1 -: $clog2(NumLogicBanks)]`.
- `req_ready_o` out 1: access accepted this cycle (grant or error).
- `req_err_o` out 1: access accepted but dropped because the target bank is powered off.
- `sram_req_o` out 1: request to SRAM; equals `req_valid_i & req_ready_o & ~req_err_o`.
- `cfg_powergate_i` in NumLogicBanks: software power-off request per bank (level).
- `deepsleep_o` out NumLogicBanks: to SRAM bank deepsleep.
- `powergate_o` out NumLogicBanks: to SRAM bank powergate.
- `bank_on_o` out NumLogicBanks: bank is in ON state.

## Operation
- One independent FSM per bank, with states SLEEP, WAKE, ON and OFF. Outputs are registered-state decodes:
  - SLEEP: deepsleep=1, powergate=0.
  - WAKE: deepsleep=0, powergate=0.
  - ON: deepsleep=0, powergate=0, bank_on=1.
  - OFF: deepsleep=1, powergate=1.
- Per-bank transitions, with priority top-down:
  - Any state with `cfg_powergate_i[b]=1` (other than OFF) → OFF.
  - OFF with `cfg_powergate_i[b]=0` → SLEEP.
  - SLEEP with valid targeting b → WAKE; wake counter loaded with 0.
  - WAKE: counter increments each cycle. When counter == WakeCycles-1 → ON; idle counter loaded with 0.
  - ON with a grant to b: idle counter cleared.
  - ON with no grant to b, when IdleCycles≠0: if idle counter == IdleCycles-1 → SLEEP; else idle counter increments.
- Handshake (combinational from current state and address):
  - ready = valid & (state[sel] ∈ {ON, OFF}).
  - err = valid & state[sel]==OFF.
- Requester rule: hold `req_valid_i` and `req_addr_i` stable until ready. Changing the address while stalled is legal; a bank already in WAKE completes its wake anyway.
- A grant in the same cycle that `cfg_powergate_i` rises still completes (sram_req_o=1); the bank enters OFF next cycle.
- Only the addressed bank reacts to a request; other banks follow their own idle/cfg rules concurrently.
- Counter widths: `$clog2(max(WakeCycles, IdleCycles)+1)`. Counters never wrap because they are reset on every state entry.

## Timing
- Reset (async, rst_i=1): all banks SLEEP. deepsleep_o='1, powergate_o='0, bank_on_o='0; req_ready_o, req_err_o, sram_req_o = 0 while valid is low. All counters 0.
- Reset mid-wake or mid-access: the bank returns to SLEEP immediately. The pending request is not remembered and the requester must re-present.
- Request to SLEEP bank, valid rising at cycle t:
  - WAKE during t+1 … t+WakeCycles.
  - ON and ready at t+WakeCycles+1, so stall is WakeCycles+1 cycles.
- Request to ON bank: ready in the same cycle (zero added latency).
- Request to OFF bank: ready=err=1 in the same cycle; sram_req_o=0.
- Auto-sleep: with the last grant at t and no further grant, the bank is ON through t+IdleCycles and SLEEP from t+IdleCycles+1.
- cfg_powergate_i rising at t → OFF from t+1. Falling at t → SLEEP from t+1; first access then costs the full wake sequence.
- The SRAM read-data latency is unaffected; the bank must not auto-sleep while read data is in flight. This is guaranteed when IdleCycles ≥ SRAM Latency.

## Test plan
- Reset then read addr 0x000 (bank 0), NumLogicBanks=4, WakeCycles=2: ready at 3rd cycle after valid. deepsleep_o[0] is 0 from the cycle after valid; other banks stay deepsleep=1.
- Back-to-back accesses to bank 1 after wake: ready every cycle, idle counter held at 0. Stop, and with IdleCycles=16 deepsleep_o[1] returns to 1 exactly 17 cycles after the last grant.
- cfg_powergate_i=4'b0100, access addr in bank 2: ready=err=1 the same cycle, sram_req_o=0, powergate_o=4'b0100. Release cfg: SLEEP next cycle; the next access pays the full wake.
- Assert cfg_powergate_i[3] while bank 3 is in WAKE with valid pending: bank goes to OFF, and the stalled request completes with err=1 in the next cycle.
- Assert rst_i during WAKE of bank 0: outputs return to reset values asynchronously. After release, the request re-triggers a full wake with stall WakeCycles+1.
- IdleCycles=0: bank 2 stays ON indefinitely after one access; sleep happens only via cfg_powergate_i.
